irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Parametrised vectored interrupt controller replacing the fixed four-line interrupt/clear scheme of the CPU.
//  Latches up to 8 sources (per-channel edge/level mode), masks and prioritises them, presents one request plus
//  a 16-bit vector to the CPU control unit, and tracks in-service channels for nested preemption.
//  Memory-mapped on the 8-bit IO bus; the CPU's global interrupt-enable flag still gates acceptance.
// PARAMETERS
//  NUM_IRQ        4        number of sources, 1..8; channel 0 = highest priority
//  VECTOR_BASE    16'h0001 vector of channel 0
//  VECTOR_STRIDE  2        vector spacing in instruction words; vector(k) = VECTOR_BASE + k*VECTOR_STRIDE
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  cs         in   1        register window selected by IO address decode
//  addr       in   3        register offset
//  din        in   8        IO write data
//  write_en   in   1        IO write strobe
//  read_en    in   1        IO read strobe
//  dout       out  8        IO read data, registered
//  irq        in   NUM_IRQ  source lines, synchronous to clk
//  irq_clr    out  NUM_IRQ  one-cycle acknowledge pulse per channel, to the source peripheral
//  int_req    out  1        request to CPU control, registered
//  int_vector out  16       vector of the requested channel, stable while int_req=1
//  int_ack    in   1        one-cycle pulse: CPU takes the presented interrupt
//  int_done   in   1        one-cycle pulse: CPU executed return-from-interrupt
// BEHAVIOUR
//  Registers (bits >= NUM_IRQ read 0, writes ignored):
//   0 PEND   R / W1C; 1 MASK R/W (1=enabled); 2 MODE R/W (1=edge, 0=level); 3 INSERV RO;
//   4 STATUS RO {int_req, 4'b0, int_id[2:0]}; 5..7 read 0.
//  Reset: PEND=0, MASK=0, MODE=all 1, INSERV=0, prev-sample=0, dout=0, irq_clr=0, int_req=0, int_vector=VECTOR_BASE.
//  Edge channel: PEND[k] set on the clock edge where irq[k]=1 and prev[k]=0. Level channel: PEND[k] = irq[k] each cycle.
//  Candidate = lowest k with PEND&MASK set and k lower than every INSERV bit (strict preemption only).
//  int_req/int_id/int_vector registered from candidate: irq edge sampled at E1 -> PEND at E1 -> int_req at E2.
//  int_ack while int_req=1, on that edge: INSERV[int_id] set; PEND[int_id] cleared (edge mode);
//   irq_clr[int_id]=1 for the next cycle only; int_req=0 the next cycle, re-evaluated after that.
//  int_ack while int_req=0: ignored. Ack always applies to the registered int_id, even if MASK changed that cycle.
//  int_done: clears the lowest-index set INSERV bit; ignored if INSERV=0.
//  Same-cycle int_done + int_ack: done clears first, then ack sets; both take effect.
//  New edge coincident with W1C or ack clear on the same channel: set wins, PEND stays 1.
//  MASK cleared while int_req=1 with no ack: int_req drops the following cycle.
//  Writes to PEND on level channels ignored. Write needs cs & write_en; one register per cycle.
//  dout = selected register on the cycle after cs & read_en, otherwise 0 (OR-muxable). Reads have no side effects.
//  Reset mid-service: all state cleared, no irq_clr pulse emitted.
// STRUCTURE
//  Shared package: register offsets IRQC_PEND..IRQC_STATUS, MAX_IRQ=8, vector arithmetic function.
//  Sub-module irq_prio_enc: NUM_IRQ-wide lowest-index-first encoder with valid output,
//   used for both candidate selection and INSERV clear.
//  Vector arithmetic: 16-bit, wraps modulo 2^16.
// TESTING
//  1 Reset, MASK=0x1, pulse irq[0] -> PEND=0x01 at E1, int_req=1 at E2, int_vector=0x0001, STATUS=0x80.
//  2 MASK=0xF, irq[2] and irq[1] together -> vector 0x0003 (ch1); ack -> irq_clr=0x2 for one cycle, INSERV=0x02;
//    two cycles later int_req=0 (ch2 blocked by in-service ch1).
//  3 Ch2 in service, irq[0] edge -> int_req with vector 0x0001 (preempt); int_done -> INSERV=0x04; int_done -> 0x00.
//  4 MODE=0 on ch3, hold irq[3]=1: ack -> PEND[3] stays 1; drop irq[3] -> PEND[3]=0 next cycle.
//  5 Write PEND=0x01 (W1C) in the same cycle as a new irq[0] edge -> PEND[0]=1.
//  6 int_ack with int_req=0; int_done with INSERV=0; reset while INSERV=0x03
//    -> no state change for the first two; all registers return to reset values after the reset.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared register map, size limits and vector arithmetic for the interrupt controller.
package irq_controller_pkg;

    localparam int MAX_IRQ = 8;

    localparam logic [2:0] IRQC_PEND   = 3'd0;
    localparam logic [2:0] IRQC_MASK   = 3'd1;
    localparam logic [2:0] IRQC_MODE   = 3'd2;
    localparam logic [2:0] IRQC_INSERV = 3'd3;
    localparam logic [2:0] IRQC_STATUS = 3'd4;

    // 16-bit vector for channel k; wraps modulo 2^16.
    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input int          stride,
                                               input logic [2:0]  k);
        return base + 16'(stride * int'(k));
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder with valid output; purely combinational.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_vld,
    output logic [2:0]   o_idx
);

    always_comb begin
        o_vld = 1'b0;
        o_idx = 3'd0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_vld = 1'b1;
                o_idx = 3'(k);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: latches, masks and prioritises sources, with nested in-service tracking.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = 16'h0001,
    parameter int          VECTOR_STRIDE = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cs,
    input  logic [2:0]         i_addr,
    input  logic [7:0]         i_din,
    input  logic               i_write_en,
    input  logic               i_read_en,
    output logic [7:0]         o_dout,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic [NUM_IRQ-1:0] o_irq_clr,
    output logic               o_int_req,
    output logic [15:0]        o_int_vector,
    input  logic               i_int_ack,
    input  logic               i_int_done
);

    logic [NUM_IRQ-1:0] r_pend, r_mask, r_mode, r_inserv, r_prev, r_irq_clr;
    logic [7:0]         r_dout;
    logic               r_int_req;
    logic [2:0]         r_int_id;
    logic [15:0]        r_int_vector;

    logic [NUM_IRQ-1:0] w_edge, w_w1c, w_ack_oh, w_done_oh, w_allow, w_cand;
    logic [NUM_IRQ-1:0] w_pend_nxt, w_inserv_nxt;
    logic               w_wr, w_ack, w_ins_vld, w_cand_vld;
    logic [2:0]         w_ins_idx, w_cand_idx;
    logic [7:0]         w_rd_dat;
    logic               w_unused_din;

    assign w_unused_din = ^i_din;

    assign w_edge    = i_irq & ~r_prev;
    assign w_wr      = i_cs & i_write_en;
    assign w_w1c     = (w_wr && i_addr == IRQC_PEND) ? i_din[NUM_IRQ-1:0] : '0;
    assign w_ack     = i_int_ack & r_int_req;
    assign w_ack_oh  = w_ack ? (NUM_IRQ'(1) << r_int_id) : '0;
    assign w_done_oh = (i_int_done && w_ins_vld) ? (NUM_IRQ'(1) << w_ins_idx) : '0;

    // Edge channels: a new edge outranks any clear on the same cycle. Level channels track the line.
    assign w_pend_nxt   = (r_mode & ((r_pend & ~(w_w1c | w_ack_oh)) | w_edge)) | (~r_mode & i_irq);
    assign w_inserv_nxt = (r_inserv & ~w_done_oh) | w_ack_oh;

    irq_prio_enc #(.N(NUM_IRQ)) u_ins_enc (
        .i_req (r_inserv),
        .o_vld (w_ins_vld),
        .o_idx (w_ins_idx)
    );

    // Only channels strictly above the highest-priority in-service channel may preempt.
    always_comb begin
        w_allow = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_allow[k] = !w_ins_vld || (k < int'(w_ins_idx));
        end
    end

    assign w_cand = r_pend & r_mask & w_allow;

    irq_prio_enc #(.N(NUM_IRQ)) u_cand_enc (
        .i_req (w_cand),
        .o_vld (w_cand_vld),
        .o_idx (w_cand_idx)
    );

    always_comb begin
        w_rd_dat = 8'h00;
        case (i_addr)
            IRQC_PEND:   w_rd_dat = 8'(r_pend);
            IRQC_MASK:   w_rd_dat = 8'(r_mask);
            IRQC_MODE:   w_rd_dat = 8'(r_mode);
            IRQC_INSERV: w_rd_dat = 8'(r_inserv);
            IRQC_STATUS: w_rd_dat = {r_int_req, 4'b0000, r_int_id};
            default:     w_rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend       <= '0;
            r_mask       <= '0;
            r_mode       <= '1;
            r_inserv     <= '0;
            r_prev       <= '0;
            r_irq_clr    <= '0;
            r_dout       <= 8'h00;
            r_int_req    <= 1'b0;
            r_int_id     <= 3'd0;
            r_int_vector <= VECTOR_BASE;
        end else begin
            r_prev    <= i_irq;
            r_pend    <= w_pend_nxt;
            r_inserv  <= w_inserv_nxt;
            r_irq_clr <= w_ack_oh;
            r_dout    <= (i_cs && i_read_en) ? w_rd_dat : 8'h00;
            if (w_wr && i_addr == IRQC_MASK) r_mask <= i_din[NUM_IRQ-1:0];
            if (w_wr && i_addr == IRQC_MODE) r_mode <= i_din[NUM_IRQ-1:0];
            // An accepted ack forces one idle cycle before the next evaluation.
            r_int_req <= w_cand_vld & ~w_ack;
            if (w_cand_vld && !w_ack) begin
                r_int_id     <= w_cand_idx;
                r_int_vector <= irq_vector(VECTOR_BASE, VECTOR_STRIDE, w_cand_idx);
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_irq_clr    = r_irq_clr;
    assign o_int_req    = r_int_req;
    assign o_int_vector = r_int_vector;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register reads go through an expected-value queue.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, write_en, read_en, int_ack, int_done;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [3:0]  irq, irq_clr;
    logic        int_req;
    logic [15:0] int_vector;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rd_exp_q[$];

    always #5 clk = ~clk;

    irq_controller #(.NUM_IRQ(4), .VECTOR_BASE(16'h0001), .VECTOR_STRIDE(2)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cs         (cs),
        .i_addr       (addr),
        .i_din        (din),
        .i_write_en   (write_en),
        .i_read_en    (read_en),
        .o_dout       (dout),
        .i_irq        (irq),
        .o_irq_clr    (irq_clr),
        .o_int_req    (int_req),
        .o_int_vector (int_vector),
        .i_int_ack    (int_ack),
        .i_int_done   (int_done)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; write_en = 1'b1; addr = a; din = d;
        step();
        cs = 1'b0; write_en = 1'b0; din = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] e;
        rd_exp_q.push_back(exp);
        cs = 1'b1; read_en = 1'b1; addr = a;
        step();
        cs = 1'b0; read_en = 1'b0;
        e = rd_exp_q.pop_front();
        chk(tag, 16'(dout), 16'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cs = 1'b0; write_en = 1'b0; read_en = 1'b0;
        addr = 3'd0; din = 8'h00; irq = 4'h0; int_ack = 1'b0; int_done = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_req", 16'(int_req), 16'd0);
        chk("rst_vec", int_vector, 16'h0001);
        chk("rst_clr", 16'(irq_clr), 16'd0);
        chk("rst_dout", 16'(dout), 16'd0);
        rd("rst_mode", 3'd2, 8'h0F);
        rd("rst_pend", 3'd0, 8'h00);

        // 1: single edge source, two-edge request latency
        wr(3'd1, 8'h01);
        irq = 4'b0001; step();
        chk("t1_req_e1", 16'(int_req), 16'd0);
        irq = 4'b0000;
        rd("t1_pend", 3'd0, 8'h01);
        chk("t1_req_e2", 16'(int_req), 16'd1);
        chk("t1_vec", int_vector, 16'h0001);
        rd("t1_status", 3'd4, 8'h80);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("t1_clr", 16'(irq_clr), 16'h1);
        chk("t1_req_ack", 16'(int_req), 16'd0);
        int_done = 1'b1; step(); int_done = 1'b0;
        chk("t1_clr_off", 16'(irq_clr), 16'h0);
        rd("t1_inserv", 3'd3, 8'h00);

        // 2: simultaneous sources, ch1 wins and blocks ch2
        wr(3'd1, 8'h0F);
        irq = 4'b0110; step();
        irq = 4'b0000; step();
        chk("t2_req", 16'(int_req), 16'd1);
        chk("t2_vec", int_vector, 16'h0003);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("t2_clr", 16'(irq_clr), 16'h2);
        step();
        chk("t2_clr_off", 16'(irq_clr), 16'h0);
        chk("t2_req_blocked", 16'(int_req), 16'd0);
        rd("t2_inserv", 3'd3, 8'h02);

        // 3: ch2 in service, ch0 preempts, then unwind
        int_done = 1'b1; step(); int_done = 1'b0;
        step();
        chk("t3_vec_ch2", int_vector, 16'h0005);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        irq = 4'b0001; step();
        irq = 4'b0000; step();
        chk("t3_req_pre", 16'(int_req), 16'd1);
        chk("t3_vec_pre", int_vector, 16'h0001);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        rd("t3_inserv_both", 3'd3, 8'h05);
        int_done = 1'b1; step(); int_done = 1'b0;
        rd("t3_inserv_1", 3'd3, 8'h04);
        int_done = 1'b1; step(); int_done = 1'b0;
        rd("t3_inserv_0", 3'd3, 8'h00);

        // 4: level-mode ch3 keeps pending through ack
        wr(3'd2, 8'h07);
        irq = 4'b1000; step(); step();
        chk("t4_vec", int_vector, 16'h0007);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        rd("t4_pend_held", 3'd0, 8'h08);
        irq = 4'b0000; step();
        rd("t4_pend_drop", 3'd0, 8'h00);
        int_done = 1'b1; step(); int_done = 1'b0;
        wr(3'd2, 8'h0F);

        // 5: W1C colliding with a new edge keeps the bit
        wr(3'd1, 8'h00);
        irq = 4'b0001;
        wr(3'd0, 8'h01);
        irq = 4'b0000;
        rd("t5_pend_set_wins", 3'd0, 8'h01);
        wr(3'd0, 8'h01);
        rd("t5_pend_w1c", 3'd0, 8'h00);

        // 6: spurious ack/done, then reset mid-service
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("t6_ack_noreq_clr", 16'(irq_clr), 16'h0);
        int_done = 1'b1; step(); int_done = 1'b0;
        rd("t6_inserv_idle", 3'd3, 8'h00);
        wr(3'd1, 8'h0F);
        irq = 4'b0010; step();
        irq = 4'b0000; step();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        irq = 4'b0001; step();
        irq = 4'b0000; step();
        int_ack = 1'b1; step(); int_ack = 1'b0;
        rd("t6_inserv_3", 3'd3, 8'h03);
        reset = 1'b1; step(); step(); reset = 1'b0;
        chk("t6_rst_req", 16'(int_req), 16'd0);
        chk("t6_rst_clr", 16'(irq_clr), 16'h0);
        chk("t6_rst_vec", int_vector, 16'h0001);
        rd("t6_rst_pend", 3'd0, 8'h00);
        rd("t6_rst_mask", 3'd1, 8'h00);
        rd("t6_rst_mode", 3'd2, 8'h0F);
        rd("t6_rst_inserv", 3'd3, 8'h00);
        rd("t6_rst_status", 3'd4, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
